// File: rtl/dev_timer.sv
`default_nettype none
// ============================================================================
// Module      : dev_timer
// Description : Bus-mapped programmable interval timer with prescaler,
//               one-shot / auto-reload modes and W1C interrupt status.
// Revision    : 1.0 - initial release
// ============================================================================
module dev_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic [31:0] D,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] Dout,
    output logic        INT
);

    localparam logic [1:0]  c_stIdle = 2'd0;
    localparam logic [1:0]  c_stLoad = 2'd1;
    localparam logic [1:0]  c_stCnt  = 2'd2;
    localparam logic [1:0]  c_stDone = 2'd3;
    localparam logic [15:0] c_psLast = 16'(PRESCALE - 1);

    logic [1:0]  r_state;
    logic [15:0] r_ps;
    logic        r_en;
    logic        r_mode;
    logic        r_im;
    logic        r_irq;
    logic [31:0] r_preset;
    logic [31:0] r_count;

    logic w_ctrlWr;
    logic w_newEn;
    logic w_newMode;
    logic w_newIm;
    logic w_tick;
    logic w_expire;
    logic w_clr;

    always_comb begin
        w_ctrlWr  = we && (A == 2'd0);
        w_newEn   = be[0] ? D[0] : r_en;
        w_newMode = be[0] ? D[1] : r_mode;
        w_newIm   = be[0] ? D[3] : r_im;
        w_tick    = (r_state == c_stCnt) && (r_ps == c_psLast);
        w_expire  = w_tick && (r_count == 32'd1);
        w_clr     = we && (A == 2'd3) && be[0] && D[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_stIdle;
            r_ps     <= 16'd0;
            r_en     <= 1'b0;
            r_mode   <= 1'b0;
            r_im     <= 1'b0;
            r_irq    <= 1'b0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
        end else begin
            if (w_ctrlWr) begin
                r_en   <= w_newEn;
                r_mode <= w_newMode;
                r_im   <= w_newIm;
            end
            if (we && (A == 2'd1)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) r_preset[8*i +: 8] <= D[8*i +: 8];
                end
            end
            // An expiry on the same edge as a W1C clear keeps the flag set
            if (w_expire)   r_irq <= 1'b1;
            else if (w_clr) r_irq <= 1'b0;

            case (r_state)
                c_stLoad: begin
                    r_count <= r_preset;
                    r_ps    <= 16'd0;
                    r_state <= (r_preset != 32'd0) ? c_stCnt : c_stDone;
                end
                c_stCnt: begin
                    if (w_tick) begin
                        r_ps <= 16'd0;
                        if (r_count != 32'd0) r_count <= r_count - 32'd1;
                        if (r_count <= 32'd1) r_state <= r_mode ? c_stLoad : c_stDone;
                    end else begin
                        r_ps <= r_ps + 16'd1;
                    end
                end
                default: ;
            endcase

            // A CTRL write overrides whatever transition the counter chose
            if (w_ctrlWr) r_state <= w_newEn ? c_stLoad : c_stIdle;
        end
    end

    always_comb begin
        case (A)
            2'd0:    Dout = {28'd0, r_im, 1'b0, r_mode, r_en};
            2'd1:    Dout = r_preset;
            2'd2:    Dout = r_count;
            default: Dout = {31'd0, r_irq};
        endcase
        INT = r_irq & r_im;
    end

endmodule
`default_nettype wire
